imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Round-robin arbiter that shares one instruction-memory read port (16-bit address, 16-bit data, RD strobe) between NUM_CORES core fetch units.
- Sits between the per-core fetch stages and the single instruction RAM instance.
- Sequences each access as arbitrate, then read, then respond. Every requester is served within a bounded number of cycles, so no core can be starved.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, instruction address width.
- DATA_W, 16, instruction word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- core_req  in  NUM_CORES  per-core fetch request, level-sensitive.
- core_addr  in  NUM_CORES*ADDR_W  per-core fetch address; core i uses bits [i*ADDR_W +: ADDR_W].
- core_gnt  out  NUM_CORES  one-hot; marks the core that currently owns the memory.
- core_rvalid  out  NUM_CORES  one-hot, single-cycle; response valid for core i.
- core_rdata  out  DATA_W  fetched word, broadcast to all cores; meaningful only when core_rvalid is non-zero.
- mem_addr  out  ADDR_W  address to the instruction RAM.
- mem_rd  out  1  read strobe to the instruction RAM.
- mem_data  in  DATA_W  instruction RAM data output (high-Z when mem_rd=0).

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; core_gnt=0, core_rvalid=0, core_rdata=0, mem_addr=0, mem_rd=0.
  - Priority pointer last=NUM_CORES-1, so core 0 has highest priority first.
  - Any in-flight access is discarded with no response; the core must re-request.
- FSM states: IDLE, READ, RESP. State is registered; outputs are registered, or decoded from registered state only.
- IDLE:
  - If any core_req bit is set, pick the first requesting core searching (last+1) mod N, (last+2) mod N, ... up to last.
  - Latch the owner index and core_addr[owner] into internal registers, then go to READ.
  - If no request is set, stay in IDLE.
- READ (exactly 1 cycle):
  - mem_rd=1, mem_addr=latched address, core_gnt[owner]=1.
  - At the closing edge: core_rdata is loaded from mem_data, last is set to owner, next state is RESP.
- RESP (exactly 1 cycle):
  - core_rvalid[owner]=1, core_gnt[owner]=1, mem_rd=0, mem_addr holds its value.
  - Next state is always IDLE.
- Latency and throughput:
  - core_req seen high in IDLE at edge k gives mem_rd high in cycle k+1 and core_rvalid in cycle k+2.
  - One access per 3 cycles.
  - Worst-case wait from req to rvalid is 3*NUM_CORES cycles.
- Requester rules:
  - A core holds core_req and core_addr stable until it sees core_rvalid.
  - It may drop core_req, or present a new address, from the edge that ends its rvalid cycle.
  - Changes to core_addr while a core is not the owner are ignored.
  - core_addr[owner] is not re-sampled after IDLE.
- core_rdata holds its last value outside RESP. It is never driven from mem_data combinationally.
- Simultaneous requests are resolved purely by the pointer. A core that just finished has the lowest priority at the next arbitration.
- A request that arrives during READ or RESP waits for the next IDLE cycle.
- Address wrap: 0xFFFF is a valid address; there is no increment logic, so no wrap handling is needed.
- Illegal state encoding: the FSM returns to IDLE.

Decomposition:
- Shared package imem_pkg:
  - ADDR_W and DATA_W constants.
  - State encoding: IDLE=2'd0, READ=2'd1, RESP=2'd2.
  - Default NUM_CORES.
- One sub-module, rr_picker: purely combinational.
  - Inputs: req vector, last pointer.
  - Outputs: valid flag, winner index, winner one-hot.
  - Reused by the planned data-memory arbiter.

Test Plan:
- Reset, then core0 requests addr 0x0010 with mem[0x0010]=0xABCD:
  - Edge +1: mem_rd=1 and mem_addr=0x0010 for exactly 1 cycle.
  - Edge +2: core_rvalid=4'b0001 for 1 cycle with core_rdata=0xABCD.
- After reset, all 4 cores request at once with addrs 0x0100..0x0103:
  - rvalid order is core0, 1, 2, 3, spaced 3 cycles apart.
  - Each core receives mem[its address].
  - core_gnt is one-hot throughout; mem_rd is never high in two consecutive cycles.
- Cores 1 and 2 request continuously, each re-requesting right after its rvalid:
  - Grants alternate 1,2,1,2 over 8 accesses.
  - Neither core ever waits more than 6 cycles.
- Assert rstn=0 mid-READ while core3 is the owner:
  - mem_rd, core_gnt and core_rvalid go to 0 immediately, before the next edge.
  - After release, a core3 request is served from scratch with the correct data.
- Core2 requests addr 0xFFFF with mem[0xFFFF]=0x1234; core2 changes core_addr to 0x0000 during READ:
  - Response is still 0x1234.
  - mem_addr stays 0xFFFF during READ.
- No requests for 20 cycles:
  - State stays IDLE; mem_rd=0, core_gnt=0, core_rvalid=0 throughout.
  - core_rdata unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and FSM encoding for the instruction-memory arbiter
package imem_pkg;

   localparam int IMEM_ADDR_W    = 16;
   localparam int IMEM_DATA_W    = 16;
   localparam int IMEM_NUM_CORES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } imem_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting after the last owner
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               valid,
   output logic [IDX_W-1:0]   winner,
   output logic [NUM_REQ-1:0] onehot
);

   // scan (last+1) mod N .. last, first set request wins
   always_comb begin
      logic [IDX_W-1:0] cand;
      valid  = 1'b0;
      winner = '0;
      onehot = '0;
      cand   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last) + i) % NUM_REQ);
         if (!valid && req[cand]) begin
            valid        = 1'b1;
            winner       = cand;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin sharing of one instruction RAM read port between cores
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int NUM_CORES = IMEM_NUM_CORES,
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int DATA_W    = IMEM_DATA_W
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_rvalid,
   output logic [DATA_W-1:0]           core_rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_rd,
   input  logic [DATA_W-1:0]           mem_data
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   imem_state_t           state;
   logic [IDX_W-1:0]      last;
   logic [IDX_W-1:0]      owner;
   logic                  pick_valid;
   logic [IDX_W-1:0]      pick_idx;
   logic [NUM_CORES-1:0]  pick_onehot;
   logic [ADDR_W-1:0]     pick_addr;

   rr_picker #(
      .NUM_REQ (NUM_CORES),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (core_req),
      .last   (last),
      .valid  (pick_valid),
      .winner (pick_idx),
      .onehot (pick_onehot)
   );

   // select the winning core's address slice
   always_comb begin
      pick_addr = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (pick_onehot[i]) begin
            pick_addr = core_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // arbitrate -> read -> respond; mem_addr doubles as the latched owner address
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         last        <= IDX_W'(NUM_CORES - 1);
         owner       <= '0;
         core_gnt    <= '0;
         core_rvalid <= '0;
         core_rdata  <= '0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               core_rvalid <= '0;
               if (pick_valid) begin
                  owner    <= pick_idx;
                  mem_addr <= pick_addr;
                  core_gnt <= pick_onehot;
                  mem_rd   <= 1'b1;
                  state    <= READ;
               end
            end
            READ: begin
               mem_rd      <= 1'b0;
               core_rdata  <= mem_data;
               core_rvalid <= core_gnt;
               last        <= owner;
               state       <= RESP;
            end
            RESP: begin
               core_rvalid <= '0;
               core_gnt    <= '0;
               state       <= IDLE;
            end
            default: begin
               core_rvalid <= '0;
               core_gnt    <= '0;
               mem_rd      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for the instruction-memory arbiter
module tb_imem_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [N-1:0]    core_req;
   logic [N*AW-1:0] core_addr;
   logic [N-1:0]    core_gnt;
   logic [N-1:0]    core_rvalid;
   logic [DW-1:0]   core_rdata;
   logic [AW-1:0]   mem_addr;
   logic            mem_rd;
   logic [DW-1:0]   mem_data;

   typedef struct {
      int          core;
      logic [15:0] data;
   } exp_t;

   exp_t         sb_q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           left[N];
   int           last_rv_cyc[N];
   int           last_any_rv;
   logic [N-1:0] rv_prev;
   logic         prev_rd;
   bit           chk_space;
   bit           chk_alt;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      case (a)
         16'h0010: return 16'hABCD;
         16'hFFFF: return 16'h1234;
         default:  return {a[7:0], a[15:8]} ^ 16'h5A5A;
      endcase
   endfunction

   assign mem_data = mem_rd ? mem_val(mem_addr) : 16'hDEAD;

   imem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .core_req    (core_req),
      .core_addr   (core_addr),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic issue(input int c, input logic [15:0] a, input int n);
      core_req[c]            = 1'b1;
      core_addr[c*AW +: AW]  = a;
      left[c]                = n - 1;
      sb_q.push_back('{core: c, data: mem_val(a)});
   endtask

   task automatic step();
      exp_t        e;
      logic [15:0] na;
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < N; c++) begin
         if (rv_prev[c]) begin
            if (left[c] > 0) begin
               left[c]--;
               na = core_addr[c*AW +: AW] + 16'd1;
               core_addr[c*AW +: AW] = na;
               sb_q.push_back('{core: c, data: mem_val(na)});
            end else begin
               core_req[c] = 1'b0;
            end
         end
      end
      if (rstn) begin
         check("gnt_onehot", 32'($onehot0(core_gnt)), 32'd1);
         check("rvalid_onehot", 32'($onehot0(core_rvalid)), 32'd1);
         check("rd_back_to_back", 32'(mem_rd & prev_rd), 32'd0);
         if (core_rvalid != '0) begin
            if (sb_q.size() == 0) begin
               check("rvalid_unexpected", 32'(core_rvalid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("rvalid_core", 32'(core_rvalid), 32'd1 << e.core);
               check("rdata", 32'(core_rdata), 32'(e.data));
               if (chk_space && last_any_rv >= 0)
                  check("rvalid_spacing", 32'(cyc - last_any_rv), 32'd3);
               if (chk_alt && last_rv_cyc[e.core] >= 0)
                  check("wait_le6", 32'((cyc - last_rv_cyc[e.core]) <= 6), 32'd1);
               last_any_rv        = cyc;
               last_rv_cyc[e.core] = cyc;
            end
         end
      end
      prev_rd = mem_rd;
      rv_prev = core_rvalid;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int i;
      i = 0;
      while ((sb_q.size() != 0 || core_req != '0) && i < budget) begin
         step();
         i++;
      end
      check({tag, "_done"}, 32'(sb_q.size() == 0 && core_req == '0), 32'd1);
   endtask

   task automatic reset_dut();
      rstn      = 1'b0;
      core_req  = '0;
      core_addr = '0;
      sb_q.delete();
      rv_prev   = '0;
      prev_rd   = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      core_req    = '0;
      core_addr   = '0;
      rv_prev     = '0;
      prev_rd     = 1'b0;
      last_any_rv = -1;
      chk_space   = 1'b0;
      chk_alt     = 1'b0;
      for (int c = 0; c < N; c++) begin
         left[c]        = 0;
         last_rv_cyc[c] = -1;
      end

      // reset state
      #12;
      check("rst_gnt", 32'(core_gnt), 32'd0);
      check("rst_rvalid", 32'(core_rvalid), 32'd0);
      check("rst_rdata", 32'(core_rdata), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      @(posedge clk);
      #3;
      rstn = 1'b1;
      step();

      // single access, latency
      issue(0, 16'h0010, 1);
      step();
      check("t1_rd", 32'(mem_rd), 32'd1);
      check("t1_addr", 32'(mem_addr), 32'h0010);
      check("t1_gnt", 32'(core_gnt), 32'b0001);
      step();
      check("t1_rd_low", 32'(mem_rd), 32'd0);
      check("t1_rvalid", 32'(core_rvalid), 32'b0001);
      wait_done(10, "t1");

      // all four at once after reset
      reset_dut();
      step();
      chk_space   = 1'b1;
      last_any_rv = -1;
      for (int c = 0; c < N; c++) issue(c, 16'h0100 + 16'(c), 1);
      wait_done(40, "t2");
      chk_space = 1'b0;

      // cores 1 and 2 continuous, 8 accesses alternating
      chk_alt = 1'b1;
      for (int c = 0; c < N; c++) last_rv_cyc[c] = -1;
      issue(1, 16'h0300, 4);
      issue(2, 16'h0400, 4);
      wait_done(60, "t3");
      chk_alt = 1'b0;

      // reset during READ with core3 owning
      issue(3, 16'h0200, 1);
      step();
      check("t4_rd", 32'(mem_rd), 32'd1);
      check("t4_gnt", 32'(core_gnt), 32'b1000);
      #2;
      rstn = 1'b0;
      #1;
      check("t4_rst_rd", 32'(mem_rd), 32'd0);
      check("t4_rst_gnt", 32'(core_gnt), 32'd0);
      check("t4_rst_rvalid", 32'(core_rvalid), 32'd0);
      sb_q.delete();
      rv_prev = '0;
      prev_rd = 1'b0;
      @(posedge clk);
      #3;
      rstn    = 1'b1;
      left[3] = 0;
      sb_q.push_back('{core: 3, data: mem_val(16'h0200)});
      wait_done(20, "t4");

      // top address, owner changes its address during READ
      issue(2, 16'hFFFF, 1);
      step();
      check("t5_rd", 32'(mem_rd), 32'd1);
      check("t5_addr_read", 32'(mem_addr), 32'hFFFF);
      core_addr[2*AW +: AW] = 16'h0000;
      #3;
      check("t5_addr_hold", 32'(mem_addr), 32'hFFFF);
      step();
      check("t5_rvalid", 32'(core_rvalid), 32'b0100);
      check("t5_addr_resp", 32'(mem_addr), 32'hFFFF);
      wait_done(10, "t5");

      // quiet period
      repeat (20) begin
         step();
         check("t6_rd", 32'(mem_rd), 32'd0);
         check("t6_gnt", 32'(core_gnt), 32'd0);
         check("t6_rvalid", 32'(core_rvalid), 32'd0);
         check("t6_rdata", 32'(core_rdata), 32'h1234);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
